// File: rtl/ozphy_ts_sched_if.sv
// Symbol stream from the Polling ordered-set scheduler toward the lane symbol path.
interface ozphy_ts_sched_if;
   logic       sym_valid;
   logic [7:0] sym_data;
   logic       sym_k;
   logic       sym_ready;

   modport master (output sym_valid, output sym_data, output sym_k, input sym_ready);
   modport slave  (input sym_valid, input sym_data, input sym_k, output sym_ready);
endinterface

// File: rtl/ozphy_ts_sched.sv
// Per-lane Polling scheduler: emits NTS TS1 then NTS TS2 ordered sets, one symbol per handshake,
// with abort honoured only on ordered-set boundaries.
module ozphy_ts_sched #(
   parameter int NTS = 1024,
   parameter int CW  = $clog2(NTS + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic             pad_fields,
   input  logic [7:0]       link_num,
   input  logic [7:0]       lane_num,
   input  logic [7:0]       n_fts,
   ozphy_ts_sched_if.master sym,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    ts1_cnt,
   output logic [CW-1:0]    ts2_cnt
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_TS1 = 2'd1, S_TS2 = 2'd2, S_DONE = 2'd3} state_t;
   localparam logic [CW-1:0] LAST_OS = CW'(NTS - 1);

   state_t        state_r, state_n;
   logic [3:0]    idx_r, idx_n;
   logic [CW-1:0] ts1_r, ts1_n, ts2_r, ts2_n;
   logic          abort_r, abort_n, done_r, done_n, valid_r, valid_n, busy_r, busy_n;
   logic          k_r, k_n, pad_r, pad_s;
   logic [7:0]    data_r, data_n, link_r, lane_r, nfts_r, link_s, lane_s, nfts_s;
   logic [8:0]    sym_s;
   logic          load_s, xfer_s, os_end_s, abort_now_s, boundary_abort_s, active_s;

   // {K, byte} for a given symbol position of a TS1/TS2 ordered set
   function automatic logic [8:0] ts_symbol(input logic [3:0] idx, input logic is_ts2, input logic pad,
                                            input logic [7:0] link, input logic [7:0] lane,
                                            input logic [7:0] nfts);
      logic [8:0] s;
      case (idx)
         4'd0:    s = {1'b1, 8'hBC};
         4'd1:    s = pad ? {1'b1, 8'hF7} : {1'b0, link};
         4'd2:    s = pad ? {1'b1, 8'hF7} : {1'b0, lane};
         4'd3:    s = {1'b0, nfts};
         4'd4:    s = {1'b0, 8'h02};
         4'd5:    s = {1'b0, 8'h00};
         default: s = is_ts2 ? {1'b0, 8'h45} : {1'b0, 8'h4A};
      endcase
      return s;
   endfunction

   assign active_s         = (state_r == S_TS1) || (state_r == S_TS2);
   assign load_s           = start && ((state_r == S_IDLE) || (state_r == S_DONE));
   assign xfer_s           = valid_r && sym.sym_ready;
   assign os_end_s         = xfer_s && (idx_r == 4'd15);
   assign abort_now_s      = abort_r || abort;
   // A COM still waiting for acceptance means no ordered set is in flight yet
   assign boundary_abort_s = abort_now_s && (idx_r == 4'd0) && !xfer_s;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_n = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_n = S_TS1;
            else       state_n = S_IDLE;
         end
         S_TS1: begin
            if (os_end_s && abort_now_s)               state_n = S_IDLE;
            else if (os_end_s && (ts1_r == LAST_OS))   state_n = S_TS2;
            else if (boundary_abort_s)                 state_n = S_IDLE;
            else                                       state_n = S_TS1;
         end
         S_TS2: begin
            if (os_end_s && (ts2_r == LAST_OS))        state_n = S_DONE;
            else if (os_end_s && abort_now_s)          state_n = S_IDLE;
            else if (boundary_abort_s)                 state_n = S_IDLE;
            else                                       state_n = S_TS2;
         end
         S_DONE: begin
            if (start)      state_n = S_TS1;
            else if (abort) state_n = S_IDLE;
            else            state_n = S_DONE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // FSM output decode: next index, counters and the symbol to present after the edge
   always_comb begin
      idx_n   = idx_r;
      ts1_n   = ts1_r;
      ts2_n   = ts2_r;
      abort_n = abort_r;
      if (load_s) begin
         idx_n   = 4'd0;
         ts1_n   = '0;
         ts2_n   = '0;
         abort_n = 1'b0;
      end else if (active_s) begin
         if (xfer_s) idx_n = idx_r + 4'd1;
         else        idx_n = idx_r;
         if (os_end_s && (state_r == S_TS1))      ts1_n = ts1_r + CW'(1);
         else if (os_end_s && (state_r == S_TS2)) ts2_n = ts2_r + CW'(1);
         else                                     ts1_n = ts1_r;
         if ((state_n == S_IDLE) || (state_n == S_DONE)) abort_n = 1'b0;
         else                                            abort_n = abort_now_s;
      end else begin
         abort_n = 1'b0;
      end
      done_n  = (state_n == S_DONE);
      valid_n = (state_n == S_TS1) || (state_n == S_TS2);
      busy_n  = valid_n;
      pad_s   = load_s ? pad_fields : pad_r;
      link_s  = load_s ? link_num   : link_r;
      lane_s  = load_s ? lane_num   : lane_r;
      nfts_s  = load_s ? n_fts      : nfts_r;
      sym_s   = ts_symbol(idx_n, state_n == S_TS2, pad_s, link_s, lane_s, nfts_s);
      if (valid_n) begin
         k_n    = sym_s[8];
         data_n = sym_s[7:0];
      end else begin
         k_n    = 1'b0;
         data_n = 8'h00;
      end
   end

   // Datapath, configuration and registered output state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_r   <= 4'd0;
         ts1_r   <= '0;
         ts2_r   <= '0;
         abort_r <= 1'b0;
         done_r  <= 1'b0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         k_r     <= 1'b0;
         data_r  <= 8'h00;
         pad_r   <= 1'b0;
         link_r  <= 8'h00;
         lane_r  <= 8'h00;
         nfts_r  <= 8'h00;
      end else begin
         idx_r   <= idx_n;
         ts1_r   <= ts1_n;
         ts2_r   <= ts2_n;
         abort_r <= abort_n;
         done_r  <= done_n;
         valid_r <= valid_n;
         busy_r  <= busy_n;
         k_r     <= k_n;
         data_r  <= data_n;
         pad_r   <= pad_s;
         link_r  <= link_s;
         lane_r  <= lane_s;
         nfts_r  <= nfts_s;
      end
   end

   assign sym.sym_valid = valid_r;
   assign sym.sym_data  = data_r;
   assign sym.sym_k     = k_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign ts1_cnt       = ts1_r;
   assign ts2_cnt       = ts2_r;
endmodule

// File: doc/ozphy_ts_sched.md
Name: ozphy_ts_sched

Overview:
- Per-lane Polling-phase ordered-set scheduler for the ozphy model.
- On start, it emits NTS TS1 ordered sets and then NTS TS2 ordered sets, one 8-bit symbol per accepted handshake, then reports done.
- Its output feeds the lane symbol path, ahead of the rxdriver and encode stage.
- The LTSSM lane state machine drives start/abort and reads done and the counters.

Parameters:
- NTS, 1024, number of TS1s and number of TS2s to send (the spec value is 1024; benches use 4).
- CW, $clog2(NTS+1), width of the sent-count outputs.

Ports:
- clk  input  1  lane clock (pcie_phy_if.clk)
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a TS1/TS2 sequence
- abort  input  1  request to stop at the next ordered-set boundary
- pad_fields  input  1  1: link and lane fields are sent as PAD; sampled at start
- link_num  input  8  link number field; sampled at start
- lane_num  input  8  lane number field; sampled at start
- n_fts  input  8  N_FTS field; sampled at start
- sym_ready  input  1  downstream accepts the current symbol
- sym_valid  output  1  sym_data/sym_k are valid
- sym_data  output  8  current symbol byte
- sym_k  output  1  1 = K-character
- busy  output  1  sequence in progress
- done  output  1  level; set after the last TS2 is accepted
- ts1_cnt  output  CW  TS1s fully sent
- ts2_cnt  output  CW  TS2s fully sent

Behaviour:
- Reset (async assert, sync release): state IDLE, sym_valid=0, sym_data=0, sym_k=0, busy=0, done=0, ts1_cnt=0, ts2_cnt=0, symbol index=0, config registers=0.
- States:
  - IDLE -> TS1 on start.
  - TS1 -> TS2 when the last symbol of TS1 number NTS is accepted.
  - TS2 -> DONE when the last symbol of TS2 number NTS is accepted.
  - DONE -> TS1 on start; DONE -> IDLE on abort.
- Start:
  - Sampled only in IDLE/DONE.
  - Ignored while busy.
  - On start, clears the counters and done, and latches pad_fields, link_num, lane_num and n_fts.
  - sym_valid rises the cycle after start; there is no idle gap.
- busy = 1 in TS1 and TS2 only.
- Ordered set: 16 symbols, index 0..15.
  - Symbol 0: 8'hBC, K=1 (COM).
  - Symbol 1: link_num, K=0; or 8'hF7, K=1 if pad.
  - Symbol 2: lane_num, K=0; or 8'hF7, K=1 if pad.
  - Symbol 3: n_fts, K=0.
  - Symbol 4: 8'h02, K=0 (rate).
  - Symbol 5: 8'h00, K=0 (training control).
  - Symbols 6-15: 8'h4A in TS1 (D10.2) or 8'h45 in TS2 (D5.2), K=0.
- Handshake:
  - A symbol transfers on a cycle with sym_valid && sym_ready.
  - While sym_valid && !sym_ready, sym_data and sym_k hold stable.
  - sym_valid is never withdrawn mid-sequence except after abort takes effect or on reset.
  - Symbols are issued back-to-back: each transfer advances the index in the same edge.
- Index wrap: on transfer of index 15, the index returns to 0 and the active counter increments in that edge.
  - In TS1 it saturates at NTS; the next symbol is then TS2 COM.
  - After the final TS2 transfer: sym_valid=0 and done=1 next cycle, with ts2_cnt=NTS.
- Abort:
  - Abort is latched (sticky) while busy.
  - It takes effect only at an ordered-set boundary: after the index-15 transfer. The ordered set in flight is never truncated.
  - If asserted while index=0 and no transfer has occurred for that OS (i.e. at a boundary, before COM is accepted), it takes effect that cycle.
  - State goes to IDLE, sym_valid=0 next cycle, and done stays 0.
  - ts1_cnt and ts2_cnt hold their final values.
  - Abort in IDLE has no effect.
- Simultaneous start and abort in IDLE/DONE: start wins.
- Counters are CW bits and never exceed NTS.
- Reset mid-sequence returns everything to reset values immediately (async).
- Latency: start to first COM valid = 1 cycle.
  - With sym_ready held high, a full sequence takes 32*NTS transfer cycles, and done rises 1 cycle after the last transfer.

Test Plan:
1. NTS=4, pad_fields=1, n_fts=8'h1F, sym_ready=1, start pulse:
   - 128 consecutive transfers.
   - Each OS reads BC(K), F7(K), F7(K), 1F, 02, 00, then ten 4A for OS 0-3 or ten 45 for OS 4-7.
   - ts1_cnt=4, ts2_cnt=4, done=1 at cycle 130, busy=0.
2. pad_fields=0, link_num=8'h00, lane_num=8'h05:
   - Symbols 1 and 2 are 00 and 05, both K=0.
   - Changing link_num mid-sequence has no effect.
3. sym_ready toggles in a pseudo-random pattern (~50%):
   - sym_data/sym_k are stable across every stalled cycle.
   - The symbol stream is identical to scenario 1.
   - The total transfer count is 128.
4. Abort asserted at the transfer of TS1#2 index 7:
   - Symbols 8-15 of that OS are still sent.
   - Then sym_valid=0, ts1_cnt=2, ts2_cnt=0, done=0, state IDLE.
5. start asserted while busy in TS2: ignored; counts and stream are unchanged.
   - Start after done: done clears, counters reset to 0, and a new sequence begins with COM.
6. reset_n pulsed low mid-symbol (async, between clock edges):
   - All outputs go to 0 immediately.
   - After release with no start, sym_valid stays 0.
